// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants and types.
// Width and branch-offset shift defaults used by datapath blocks.
package mips_pkg;

    localparam int DATA_WIDTH   = 32;
    localparam int BRANCH_SHIFT = 2;

    typedef logic [DATA_WIDTH-1:0] word_t;

endpackage : mips_pkg

// File: rtl/shift_left32.sv
// Registered logical left shift by a constant amount; with the default SHIFT
// of 2 it turns a word offset into a byte offset for the branch-target adder.
module shift_left32
    import mips_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH,
    parameter int SHIFT = BRANCH_SHIFT
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out
);

    if (SHIFT < 0 || SHIFT >= WIDTH) begin : g_bad_shift
        $error("shift_left32: SHIFT=%0d outside 0..WIDTH-1 (WIDTH=%0d)", SHIFT, WIDTH);
    end

    logic [WIDTH-1:0] out_d;
    logic [WIDTH-1:0] out_q;

    // Shift operator keeps SHIFT=0 legal without a zero-width slice.
    always_comb begin
        out_d = in << SHIFT;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign out = out_q;

endmodule : shift_left32

// File: tb/tb_shift_left32.sv
// Scoreboard bench for shift_left32: stimulus queues expectations,
// a monitor pops one entry per clock and compares all three instances.
module tb_shift_left32;

    typedef struct {
        string       name;
        logic [31:0] e2;
        logic [31:0] e0;
        logic [31:0] e4;
        bit          c0;
        bit          c4;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] din;
    logic [31:0] out2;
    logic [31:0] out0;
    logic [31:0] out4;

    exp_t sb[$];
    int   passed;
    int   total;

    shift_left32 dut2 (.Clk(clk), .Rst_n(rst_n), .in(din), .out(out2));
    shift_left32 #(.SHIFT(0)) dut0 (.Clk(clk), .Rst_n(rst_n), .in(din), .out(out0));
    shift_left32 #(.SHIFT(4)) dut4 (.Clk(clk), .Rst_n(rst_n), .in(din), .out(out4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Drive one vector on the falling edge and queue what the next rising edge must produce.
    task automatic issue(input string name, input logic [31:0] v, input logic [31:0] e2,
                         input bit c0, input logic [31:0] e0,
                         input bit c4, input logic [31:0] e4);
        exp_t x;
        @(negedge clk);
        din  = v;
        x.name = name;
        x.e2 = e2;
        x.e0 = e0;
        x.e4 = e4;
        x.c0 = c0;
        x.c4 = c4;
        sb.push_back(x);
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                x = sb.pop_front();
                check({x.name, "_s2"}, out2, x.e2);
                if (x.c0) check({x.name, "_s0"}, out0, x.e0);
                if (x.c4) check({x.name, "_s4"}, out4, x.e4);
            end
        end
    end

    initial begin : stimulus
        passed = 0;
        total  = 0;
        rst_n  = 1'b1;
        din    = 32'hFFFF_FFFF;

        // Asynchronous reset assertion mid-cycle
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_s2", out2, 32'h0);
        check("rst_async_s0", out0, 32'h0);
        check("rst_async_s4", out4, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_hold_s2", out2, 32'h0);
        check("rst_hold_s0", out0, 32'h0);

        @(negedge clk);
        rst_n = 1'b1;
        din   = 32'h0;
        sb.push_back('{name: "zero", e2: 32'h0, e0: 32'h0, e4: 32'h0, c0: 1'b1, c4: 1'b1});

        // Primary vector, including the no-early-change check
        issue("primary", 32'hDCFF_FFFF, 32'h73FF_FFFC, 1'b0, 32'h0, 1'b0, 32'h0);
        #1;
        check("primary_latency", out2, 32'h0);

        issue("b_one",  32'h0000_0001, 32'h0000_0004, 1'b0, 32'h0, 1'b0, 32'h0);
        issue("b_ones", 32'hFFFF_FFFF, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0, 32'h0);
        issue("b_b29",  32'h2000_0000, 32'h8000_0000, 1'b0, 32'h0, 1'b0, 32'h0);
        issue("b_b30",  32'h4000_0000, 32'h0000_0000, 1'b0, 32'h0, 1'b0, 32'h0);
        issue("b_b31",  32'h8000_0000, 32'h0000_0000, 1'b0, 32'h0, 1'b0, 32'h0);

        issue("btb_0",  32'h0000_0003, 32'h0000_000C, 1'b0, 32'h0, 1'b0, 32'h0);
        issue("btb_1",  32'h0000_0010, 32'h0000_0040, 1'b0, 32'h0, 1'b0, 32'h0);
        issue("btb_2",  32'h3FFF_FFFF, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0, 32'h0);

        issue("sweep_a5", 32'hA5A5_A5A5, 32'h9696_9694, 1'b1, 32'hA5A5_A5A5, 1'b0, 32'h0);
        issue("sweep_0f", 32'h0F00_0001, 32'h3C00_0004, 1'b0, 32'h0, 1'b1, 32'hF000_0010);

        // Reset pulse mid-stream between edges
        issue("stream", 32'h1234_5678, 32'h48D1_59E0, 1'b0, 32'h0, 1'b0, 32'h0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst_s2", out2, 32'h0);
        check("midrst_s4", out4, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        din   = 32'h0000_0005;
        sb.push_back('{name: "post_rst", e2: 32'h0000_0014, e0: 32'h0000_0005, e4: 32'h0000_0050,
                       c0: 1'b1, c4: 1'b1});

        // Bounded drain of the scoreboard
        for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
        #2;
        total++;
        if (sb.size() == 0) begin
            passed++;
        end else begin
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule : tb_shift_left32

// File: doc/shift_left32.md
Name: shift_left32

Overview:
- Registered logical left-shift stage for the MIPS datapath.
- Takes a 32-bit word, typically the sign-extended branch/jump offset, and produces it multiplied by 4 (word-to-byte address conversion) for the branch-target adder.
- Output is captured on the clock, giving one cycle of latency, and is cleared by an asynchronous active-low reset.

Parameters:
- WIDTH, 32: data width of in/out in bits.
- SHIFT, 2: constant left-shift amount. Legal range 0..WIDTH-1; elaboration error outside that range.

Ports:
- Clk  input  1  system clock; rising-edge active.
- Rst_n  input  1  asynchronous reset, active-low.
- in  input  WIDTH  data word to be shifted.
- out  output  WIDTH  registered result, in shifted left by SHIFT.

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset:
  - When Rst_n falls, out goes to 0 immediately, with no clock edge needed.
  - out holds 0 while Rst_n is low.
  - The first capture occurs on the first rising Clk edge after Rst_n is high.
- Function: on each rising Clk edge with Rst_n high, out <= (in << SHIFT) truncated to WIDTH bits.
  - out[WIDTH-1:SHIFT] = in[WIDTH-1-SHIFT:0].
  - out[SHIFT-1:0] = 0.
- Arithmetic rules:
  - The shift is logical; sign is not preserved.
  - The top SHIFT bits of in are discarded with no overflow flag.
- Latency: exactly 1 cycle. A change on in is visible on out after the next rising Clk edge, not before.
- Throughput: one new word per cycle; no handshake and no stall input.
- SHIFT = 0: block degenerates to a plain WIDTH-bit register.
- Reset mid-operation: the in-flight word is lost and out = 0. The next capture after release uses the value of in at that edge.
- Reset release coincident with a Clk edge: that edge is not guaranteed to capture. Capture is guaranteed from the following edge.
- X/Z on in propagates to out. The block does not mask or sanitise its input.
- No combinational path from in to out.

Decomposition:
- Shared package (mips_pkg): DATA_WIDTH = 32 and BRANCH_SHIFT = 2 constants, plus a word_t typedef (logic [31:0]) used by datapath blocks.
- Single module with one always block for the register and a continuous shift expression.
- No sub-module is warranted. The shift is pure wiring; only the output register holds state.

Test Plan:
- Reset: assert Rst_n=0 mid-cycle with in=0xFFFFFFFF -> out=0x00000000 immediately and stays 0 across clock edges while Rst_n=0.
- Primary vector: Rst_n=1, in=0x00000000 then in=0xDCFFFFFF -> out=0x00000000 until the next rising edge, then out=0x73FFFFFC.
- Boundaries, one vector per cycle, each checked after one edge:
  - in=0x00000001 -> out=0x00000004
  - in=0xFFFFFFFF -> out=0xFFFFFFFC
  - in=0x20000000 -> out=0x80000000
  - in=0x40000000 -> out=0x00000000
  - in=0x80000000 -> out=0x00000000
- Latency/back-to-back: apply in=0x00000003, 0x00000010, 0x3FFFFFFF on consecutive edges -> out=0x0000000C, 0x00000040, 0xFFFFFFFC, each exactly one cycle after its input.
- Reset mid-stream: streaming in=0x12345678 (out=0x48D159E0), pulse Rst_n low between edges -> out=0 at once; after release with in=0x00000005 -> out=0x00000014 on the following edge.
- Parameter sweep: instantiate with SHIFT=0 and in=0xA5A5A5A5 -> out=0xA5A5A5A5 after one edge; with SHIFT=4 and in=0x0F000001 -> out=0xF0000010.
